// File: rtl/multi_timer.sv
// Multi-channel interval timer: one shared prescaler strobe drives CHANNELS
// independent one-shot/periodic tick counters. No derived clocks are generated.

module multi_timer_chan #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_value,
    output logic             done_pulse,
    output logic             toggle_out,
    output logic             busy,
    output logic [WIDTH-1:0] count_value
);
    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             tog_q, tog_d;
    logic             at_term;

    // term is never 0 in RUN, so term-1 cannot underflow there
    assign at_term = (cnt_q == (term_q - WIDTH'(1)));

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            term_q  <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            tog_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            term_q  <= term_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            tog_q   <= tog_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        term_d  = term_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        tog_d   = tog_q;
        case (state_q)
            S_IDLE: begin
                if (start && !stop && (load_value != '0)) begin
                    state_d = S_RUN;
                    term_d  = load_value;
                    mode_d  = mode;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (tick) begin
                    if (at_term) begin
                        done_d = 1'b1;
                        tog_d  = ~tog_q;
                        cnt_d  = '0;
                        if (!mode_q) state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == S_RUN);
        count_value = cnt_q;
        done_pulse  = done_q;
        toggle_out  = tog_q;
    end
endmodule

module multi_timer #(
    parameter int CHANNELS  = 2,
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 50000000,
    parameter int PRE_WIDTH = 26
) (
    input  logic                      clk_in,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       mode,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    output logic                      tick_out,
    output logic [CHANNELS-1:0]       done_pulse,
    output logic [CHANNELS-1:0]       toggle_out,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS*WIDTH-1:0] count_value
);
    localparam logic [PRE_WIDTH-1:0] PC_LAST = PRE_WIDTH'(PRESCALE - 1);

    logic [PRE_WIDTH-1:0] pc_q, pc_d;
    logic                 tick_q;

    // With PRESCALE=1 PC_LAST is 0, so pc stays 0 and the strobe stays high
    always_comb pc_d = (pc_q == PC_LAST) ? '0 : pc_q + PRE_WIDTH'(1);

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= '0;
            tick_q <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            tick_q <= (pc_q == PC_LAST);
        end
    end

    assign tick_out = tick_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        multi_timer_chan #(.WIDTH(WIDTH)) u_chan (
            .clk_in      (clk_in),
            .reset_n     (reset_n),
            .tick        (tick_q),
            .start       (start[g]),
            .stop        (stop[g]),
            .mode        (mode[g]),
            .load_value  (load_value[g*WIDTH +: WIDTH]),
            .done_pulse  (done_pulse[g]),
            .toggle_out  (toggle_out[g]),
            .busy        (busy[g]),
            .count_value (count_value[g*WIDTH +: WIDTH])
        );
    end
endmodule

// File: tb/tb_multi_timer.sv
// Randomized bench for multi_timer: closed-form tick arithmetic model plus a
// queue of expected done_pulse edges consumed by an independent monitor.

module tb_multi_timer;
    localparam int CH = 2;
    localparam int W  = 8;
    localparam int P  = 4;
    localparam int PW = 3;

    logic                clk_in = 1'b0;
    logic                reset_n = 1'b0;
    logic [CH-1:0]       start, stop, mode;
    logic [CH*W-1:0]     load_value;
    logic                tick_out;
    logic [CH-1:0]       done_pulse, toggle_out, busy;
    logic [CH*W-1:0]     count_value;

    multi_timer #(.CHANNELS(CH), .WIDTH(W), .PRESCALE(P), .PRE_WIDTH(PW)) dut (
        .clk_in      (clk_in),
        .reset_n     (reset_n),
        .start       (start),
        .stop        (stop),
        .mode        (mode),
        .load_value  (load_value),
        .tick_out    (tick_out),
        .done_pulse  (done_pulse),
        .toggle_out  (toggle_out),
        .busy        (busy),
        .count_value (count_value)
    );

    always #5 clk_in = ~clk_in;

    // Edge number since reset release: edge 1 is the first rising edge
    int ec;
    always @(posedge clk_in or negedge reset_n)
        if (!reset_n) ec <= 0;
        else          ec <= ec + 1;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    // Model per channel: run start edge, N, mode, stop edge, toggles before this run
    int m_run[CH], m_E[CH], m_N[CH], m_md[CH], m_S[CH], m_tb[CH];
    int expq[CH][$];
    int st[CH], sp[CH], md[CH], lv[CH];

    // Number of tick-seen edges (P*k+1, k>=1) at or before edge x
    function automatic int tk(int x);
        return (x >= 1) ? (x - 1) / P : 0;
    endfunction

    function automatic void evalc(int c, int e, output int bsy, output int cnt, output int togs);
        int lim, n;
        togs = m_tb[c]; bsy = 0; cnt = 0;
        if (m_run[c] == 0) return;
        lim = (m_S[c] != 0 && e >= m_S[c]) ? m_S[c] - 1 : e;
        n = tk(lim) - tk(m_E[c]);
        if (m_md[c] == 0) begin
            if (n >= m_N[c]) togs++;
            else if (lim == e) begin bsy = 1; cnt = n; end
        end else begin
            togs += n / m_N[c];
            if (lim == e) begin bsy = 1; cnt = n % m_N[c]; end
        end
    endfunction

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ec);
        end
    endtask

    task automatic clr();
        for (int c = 0; c < CH; c++) begin st[c] = 0; sp[c] = 0; md[c] = 0; lv[c] = 0; end
    endtask

    // Drive inputs for the next edge and record its effect in the model
    task automatic apply();
        int e, b, cn, tg, t;
        e = ec + 1;
        for (int c = 0; c < CH; c++) begin
            start[c] = st[c][0];
            stop[c]  = sp[c][0];
            mode[c]  = md[c][0];
            load_value[c*W +: W] = lv[c][W-1:0];
            evalc(c, e - 1, b, cn, tg);
            if (b != 0 && sp[c] != 0) begin
                m_S[c] = e;
                while (expq[c].size() > 0 && expq[c][$] >= e) void'(expq[c].pop_back());
            end else if (b == 0 && st[c] != 0 && sp[c] == 0 && lv[c] != 0) begin
                m_tb[c] = tg; m_run[c] = 1; m_E[c] = e; m_N[c] = lv[c];
                m_md[c] = md[c]; m_S[c] = 0;
                t = (tk(e) + lv[c]) * P + 1;
                if (md[c] == 0) expq[c].push_back(t);
                else for (; t < e + 3000; t += lv[c] * P) expq[c].push_back(t);
            end
        end
    endtask

    task automatic cyc();
        apply();
        @(negedge clk_in);
    endtask

    task automatic idle(int n);
        repeat (n) begin clr(); cyc(); end
    endtask

    // Monitor: compares DUT outputs against the model after every edge
    initial begin
        int e, b, cn, tg, x;
        forever begin
            @(posedge clk_in);
            #1;
            if (mon_en && reset_n) begin
                e = ec;
                chk("tick_out", int'(tick_out), (e % P == 0) ? 1 : 0);
                for (int c = 0; c < CH; c++) begin
                    evalc(c, e, b, cn, tg);
                    chk($sformatf("busy[%0d]", c), int'(busy[c]), b);
                    chk($sformatf("count_value[%0d]", c), int'(count_value[c*W +: W]), cn);
                    chk($sformatf("toggle_out[%0d]", c), int'(toggle_out[c]), tg % 2);
                    if (done_pulse[c]) begin
                        if (expq[c].size() == 0) begin
                            checks++; errors++;
                            $display("FAIL done_pulse[%0d]: unexpected pulse at edge %0d", c, e);
                        end else begin
                            x = expq[c].pop_front();
                            chk($sformatf("done_edge[%0d]", c), e, x);
                        end
                    end
                    while (expq[c].size() > 0 && expq[c][0] < e) begin
                        checks++; errors++;
                        $display("FAIL done_pulse[%0d]: missing pulse, expected edge %0d, now %0d",
                                 c, expq[c][0], e);
                        void'(expq[c].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int t, r;
        start = '0; stop = '0; mode = '0; load_value = '0;
        clr();
        for (int c = 0; c < CH; c++) begin m_run[c] = 0; m_S[c] = 0; m_tb[c] = 0; end
        repeat (3) @(negedge clk_in);
        chk("rst_tick", int'(tick_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done_pulse), 0);
        chk("rst_toggle", int'(toggle_out), 0);
        chk("rst_count", int'(count_value), 0);
        reset_n = 1'b1;
        mon_en  = 1;
        idle(12);

        // ch0 one-shot, 3 ticks
        clr(); st[0] = 1; lv[0] = 3; cyc();
        idle(20);

        // ch1 periodic, 2 ticks, then stop
        clr(); st[1] = 1; md[1] = 1; lv[1] = 2; cyc();
        idle(40);
        clr(); sp[1] = 1; cyc();
        idle(4);

        // ch0 N=5: restart during RUN ignored, stop on terminal edge
        clr(); st[0] = 1; lv[0] = 5; cyc();
        idle(3);
        clr(); st[0] = 1; lv[0] = 2; cyc();
        if (expq[0].size() == 0) begin
            checks++; errors++;
            $display("FAIL stop_terminal: no pending terminal edge for ch0");
        end else begin
            t = expq[0][0];
            while (ec < t - 1) idle(1);
            clr(); sp[0] = 1; cyc();
        end
        idle(3);
        clr(); st[0] = 1; lv[0] = 0; cyc();
        idle(3);
        clr(); st[0] = 1; sp[0] = 1; lv[0] = 7; cyc();
        idle(3);

        // Full-range one-shot
        clr(); st[0] = 1; lv[0] = 255; cyc();
        idle(255 * P + 2 * P);

        // Random traffic
        repeat (600) begin
            clr();
            for (int c = 0; c < CH; c++) begin
                r = $urandom_range(0, 99);
                md[c] = $urandom_range(0, 1);
                lv[c] = $urandom_range(0, 6);
                if (r < 8) begin
                    st[c] = 1;
                    if (r < 1) sp[c] = 1;
                end else if (r < 11) begin
                    sp[c] = 1;
                end
            end
            cyc();
        end
        clr(); for (int c = 0; c < CH; c++) sp[c] = 1; cyc();
        idle(4);

        // Asynchronous reset in the middle of a run
        clr(); st[0] = 1; md[0] = 1; lv[0] = 3; st[1] = 1; lv[1] = 6; cyc();
        idle(10);
        @(posedge clk_in);
        #3;
        mon_en  = 0;
        reset_n = 1'b0;
        #1;
        chk("async_rst_tick", int'(tick_out), 0);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(done_pulse), 0);
        chk("async_rst_toggle", int'(toggle_out), 0);
        chk("async_rst_count", int'(count_value), 0);
        start = '0; stop = '0; mode = '0; load_value = '0;
        for (int c = 0; c < CH; c++) begin
            m_run[c] = 0; m_S[c] = 0; m_tb[c] = 0;
            expq[c].delete();
        end
        @(negedge clk_in);
        @(negedge clk_in);
        reset_n = 1'b1;
        mon_en  = 1;
        idle(14);

        for (int c = 0; c < CH; c++)
            chk($sformatf("pending_done[%0d]", c), expq[c].size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel interval timer, successor to the single-purpose enable counter and clock divider. A shared free-running prescaler turns the system clock into a one-cycle tick strobe. Each of CHANNELS independent channels counts ticks up to a programmable terminal value in one-shot or periodic mode. It supplies the 5 s / 10 s style latencies and slow blink outputs to the controller FSMs from a single block, without generating derived clocks.

## Interface
- CHANNELS, 2: number of independent timer channels (>= 1)
- WIDTH, 8: channel counter/terminal width; max interval 2^WIDTH-1 ticks
- PRESCALE, 50000000: clk_in cycles per tick (>= 1)
- PRE_WIDTH, 26: prescaler counter width; must satisfy 2^PRE_WIDTH >= PRESCALE
- clk_in  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  CHANNELS  per-channel start request, level-sampled each cycle
- stop  input  CHANNELS  per-channel abort, level-sampled each cycle
- mode  input  CHANNELS  per-channel mode, sampled at start: 0 = one-shot, 1 = periodic
- load_value  input  CHANNELS*WIDTH  terminal tick count, sampled at start; channel i uses bits [i*WIDTH +: WIDTH]
- tick_out  output  1  registered prescaler strobe, one cycle high per PRESCALE cycles
- done_pulse  output  CHANNELS  registered one-cycle pulse at each terminal count
- toggle_out  output  CHANNELS  flips on every done_pulse (50% duty in periodic mode)
- busy  output  CHANNELS  1 while the channel is in RUN
- count_value  output  CHANNELS*WIDTH  current tick count per channel

## Operation
- Prescaler pc (PRE_WIDTH bits): counts 0..PRESCALE-1, then wraps to 0.
  - Free-running from reset release, independent of channel state.
  - tick_out <= (pc == PRESCALE-1).
  - PRESCALE = 1: tick_out is held high from the first cycle after reset release.
- Each channel has a state machine with two states, IDLE and RUN, plus registers cnt (WIDTH), term (WIDTH) and mode_r.
- IDLE:
  - start=1, stop=0, load_value != 0: capture term <= load_value and mode_r <= mode, set cnt <= 0, go to RUN.
  - start with load_value == 0: ignored, stays IDLE.
  - start=1 and stop=1 together: stop wins, stays IDLE.
  - IDLE ignores ticks.
- RUN, in priority order:
  - stop=1: go to IDLE, cnt <= 0, no done_pulse, toggle_out unchanged.
  - tick_out=1 and cnt == term-1: done_pulse <= 1, toggle_out flips, cnt <= 0.
    - mode_r = 0: go to IDLE.
    - mode_r = 1: stay in RUN.
  - tick_out=1 otherwise: cnt <= cnt+1.
  - start while in RUN is ignored. Restarting requires stop and then a new start.
- Arithmetic:
  - Unsigned, WIDTH bits. Terminal compare is against term-1, so load_value = N gives exactly N ticks per period.
  - cnt never exceeds term-1 and never wraps through 2^WIDTH.
- Outputs:
  - busy = (state == RUN).
  - count_value = cnt. It reads 0 in IDLE.
  - Channels share only tick_out and never interact otherwise.
- Reset (reset_n=0, asynchronous, any time including mid-run):
  - pc=0, tick_out=0, all channels to IDLE.
  - cnt=0, term=0, mode_r=0.
  - done_pulse=0, toggle_out=0, busy=0, count_value=0.

## Timing
- First tick_out high in the cycle after PRESCALE rising edges following reset_n deassertion, then exactly every PRESCALE cycles.
- Start accepted at edge E: busy=1 from E. A tick_out that is high in the cycle before E is not counted.
- done_pulse:
  - Asserted in the cycle after the tick cycle on which the N-th counted tick is seen, for exactly 1 cycle.
  - busy drops in the same cycle for one-shot mode.
- First interval after start is N-1 to N full tick periods plus phase, because the prescaler is shared. Subsequent periodic intervals are exactly N*PRESCALE cycles.
- stop at the edge where the terminal tick is seen: stop wins, no pulse, no toggle.
- One-shot retrigger: start may be accepted at the edge after busy falls (i.e. while done_pulse is high).

## Test plan
- Reset release, PRESCALE=4 -> tick_out high at cycles 4, 8, 12… after release. done_pulse, toggle_out, busy and count_value stay 0.
- Ch0 one-shot, load_value=3, PRESCALE=4:
  - done_pulse[0] for 1 cycle after the 3rd counted tick.
  - busy[0] falls in the same cycle; toggle_out[0]=1.
  - count_value walks 0, 1, 2, 0.
- Ch1 periodic, load_value=2, PRESCALE=4 -> done_pulse[1] every 8 cycles, toggle_out[1] period 16 cycles. Ch0 unaffected.
- Ch0 running with load_value=5:
  - stop asserted on the terminal tick edge -> no done_pulse, busy=0, count_value=0, toggle unchanged.
  - start with load_value=0 -> ignored.
  - start during RUN -> count continues uninterrupted.
- start and stop together in IDLE -> remains IDLE. Start again with load_value=255, WIDTH=8 -> done after exactly 255 counted ticks, no wrap.
- reset_n pulsed low mid-run (asynchronous, between edges) -> all outputs 0 immediately. After release, channels stay IDLE and the prescaler restarts from 0.
